// File: rtl/seq_mult4_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_mult4_ctrl_pkg;

  // Default operand width; the product is twice this wide.
  localparam int unsigned DefaultWidth = 4;

  // Controller states.
  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Step counter width: enough bits to count 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult4_ctrl_if.sv
// Start/operand/result bundle between a requester and the multiplier.
interface seq_mult4_ctrl_if
  import seq_mult4_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic               Start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               Busy;
  logic               Done;
  logic [2*WIDTH-1:0] Product;

  // Requester side.
  modport master (
    output Start,
    output A,
    output B,
    input  Busy,
    input  Done,
    input  Product
  );

  // Multiplier side.
  modport slave (
    input  Start,
    input  A,
    input  B,
    output Busy,
    output Done,
    output Product
  );

endinterface

// File: rtl/seq_mult4_ctrl_add_nbit.sv
// Width-bit ripple-carry adder: half adder in bit 0, full adders above.
module add_nbit #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o,
  output logic             cout_o
);

  // carry[i] is the carry into bit i.
  logic [Width:1] carry;

  for (genvar i = 0; i < Width; i++) begin : g_cell
    if (i == 0) begin : g_ha
      assign sum_o[i]     = a_i[i] ^ b_i[i];
      assign carry[i + 1] = a_i[i] & b_i[i];
    end else begin : g_fa
      assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[Width];

endmodule

// File: rtl/seq_mult4_ctrl.sv
// Sequential unsigned shift-add multiplier controller: one add/shift step per
// cycle, fixed latency of WIDTH cycles from Start acceptance to Done.
module seq_mult4_ctrl
  import seq_mult4_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic            Clk,
  input logic            Rst_n,
  seq_mult4_ctrl_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  // acc = {high half (partial sum), low half (remaining multiplier bits)}
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     product_q, product_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic [WIDTH:0]    hi_next;
  logic [PW-1:0]     acc_step;
  logic              last_step;

  add_nbit #(
    .Width(WIDTH)
  ) u_add (
    .a_i   (acc_q[PW-1:WIDTH]),
    .b_i   (mcand_q),
    .sum_o (sum),
    .cout_o(cout)
  );

  // One shift-add step: conditional add into the high half, then shift
  // {carry, high, low} right by one.
  always_comb begin
    hi_next = {1'b0, acc_q[PW-1:WIDTH]};
    if (acc_q[0]) begin
      hi_next = {cout, sum};
    end
    acc_step  = {hi_next, acc_q[WIDTH-1:1]};
    last_step = (cnt_q == CntW'(WIDTH - 1));
  end

  // Next-state and datapath load decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.Start) begin
          state_d = StRun;
          cnt_d   = '0;
          mcand_d = bus.A;
          acc_d   = {{WIDTH{1'b0}}, bus.B};
        end
      end
      StRun: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CntW'(1);
        if (last_step) begin
          state_d   = StIdle;
          product_d = acc_step;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, operand, accumulator and result registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign bus.Busy    = (state_q == StRun);
  assign bus.Done    = done_q;
  assign bus.Product = product_q;

endmodule

// File: tb/tb_seq_mult4_ctrl.sv
// Scoreboard bench for seq_mult4_ctrl: a cycle-level reference model pushes
// expected products on acceptance; a monitor pops them on Done.
module tb_seq_mult4_ctrl;
  import seq_mult4_ctrl_pkg::*;

  localparam int unsigned W = DefaultWidth;

  logic Clk = 1'b0;
  logic Rst_n;

  seq_mult4_ctrl_if #(.WIDTH(W)) bus ();

  seq_mult4_ctrl #(
    .WIDTH(W)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int prod;
    int due;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int cyc      = 0;  // index of the most recent rising edge
  int rem      = 0;  // steps still to run for the operation in flight
  int inflight = 0;
  int mdl_prod = 0;
  bit mdl_done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: operation accepted when idle, finishes WIDTH edges later.
  initial begin
    forever begin
      @(posedge Clk);
      cyc++;
      mdl_done = 1'b0;
      if (!Rst_n) begin
        rem      = 0;
        mdl_prod = 0;
        exp_q.delete();
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          mdl_done = 1'b1;
          mdl_prod = inflight;
        end
      end else if (bus.Start) begin
        exp_t e;
        inflight = int'(bus.A) * int'(bus.B);
        e.prod   = inflight;
        e.due    = cyc + int'(W);
        exp_q.push_back(e);
        rem = int'(W);
      end
    end
  end

  // Monitor: per-cycle status checks, scoreboard pop on Done.
  initial begin
    forever begin
      @(negedge Clk);
      check("busy", int'(bus.Busy), int'(rem > 0));
      check("done", int'(bus.Done), int'(mdl_done));
      check("product_hold", int'(bus.Product), mdl_prod);
      if (bus.Done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_done: got Done=1, required no pending result (edge %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("product", int'(bus.Product), e.prod);
          check("latency", cyc, e.due);
        end
      end
    end
  end

  // Inputs for the next rising edge are set on the falling edge.
  task automatic drive(input bit rst, input bit s, input int a, input int b);
    @(negedge Clk);
    Rst_n     = rst;
    bus.Start = s;
    bus.A     = a[W-1:0];
    bus.B     = b[W-1:0];
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 0, 0);
  endtask

  // Start one operation, then scramble Start/A/B while it runs.
  task automatic do_op(input int a, input int b);
    drive(1'b1, 1'b1, a, b);
    repeat (W) begin
      drive(1'b1, bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    Rst_n     = 1'b0;
    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);

    // Corner operands.
    do_op(15, 15);
    do_op(13, 11);
    do_op(0, 15);
    idle(2);

    // Restart attempt two edges into a run.
    drive(1'b1, 1'b1, 3, 5);
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 7, 7);
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    idle(2);

    // Start held high through Done: second operation follows immediately.
    drive(1'b1, 1'b1, 2, 3);
    repeat (W + 1) drive(1'b1, 1'b1, 6, 9);
    idle(W);
    idle(2);

    // Reset two edges into a run, then a normal operation.
    drive(1'b1, 1'b1, 9, 9);
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 0, 0);
    do_op(1, 1);
    idle(2);

    // Every operand pair, back to back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(a, b);
      end
    end
    idle(2);

    // Free-running random traffic with occasional resets.
    repeat (300) begin
      drive(bit'($urandom_range(0, 40) != 0), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    idle(W + 2);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
